// File: rtl/route_compute_unit.sv
// Route-computation pipeline stage for one mesh-router input port.
// Head flits pick an output port by dimension-ordered routing; the choice is held for the packet.
module route_compute_unit #(
  parameter int X_W    = 2,
  parameter int Y_W    = 2,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [X_W+Y_W-1:0]   node_addr,
  input  logic                 dim_order,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_head,
  input  logic                 in_tail,
  input  logic [X_W+Y_W-1:0]   in_dest,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0]           out_dir,
  output logic                 out_head,
  output logic                 out_tail,
  output logic [DATA_W-1:0]    out_data,
  output logic                 busy,
  output logic                 err
);

  localparam int A_W = X_W + Y_W;

  localparam logic [2:0] DIR_LOCAL = 3'b000;
  localparam logic [2:0] DIR_NORTH = 3'b001;
  localparam logic [2:0] DIR_SOUTH = 3'b010;
  localparam logic [2:0] DIR_EAST  = 3'b011;
  localparam logic [2:0] DIR_WEST  = 3'b100;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_t;

  // Resolve one dimension first; fall through to the other only when the first already matches.
  function automatic logic [2:0] route_dir(
    input logic [A_W-1:0] src,
    input logic [A_W-1:0] dst,
    input logic           order
  );
    logic [X_W-1:0] sx;
    logic [X_W-1:0] dx;
    logic [Y_W-1:0] sy;
    logic [Y_W-1:0] dy;
    logic [2:0]     x_dir;
    logic [2:0]     y_dir;
    sx = src[A_W-1:Y_W];
    dx = dst[A_W-1:Y_W];
    sy = src[Y_W-1:0];
    dy = dst[Y_W-1:0];
    if (dx > sx) begin
      x_dir = DIR_SOUTH;
    end else if (dx < sx) begin
      x_dir = DIR_NORTH;
    end else begin
      x_dir = DIR_LOCAL;
    end
    if (dy > sy) begin
      y_dir = DIR_WEST;
    end else if (dy < sy) begin
      y_dir = DIR_EAST;
    end else begin
      y_dir = DIR_LOCAL;
    end
    if (order == 1'b0) begin
      route_dir = (y_dir != DIR_LOCAL) ? y_dir : x_dir;
    end else begin
      route_dir = (x_dir != DIR_LOCAL) ? x_dir : y_dir;
    end
  endfunction

  state_t              state_r;
  state_t              state_nxt_s;
  logic                out_valid_r;
  logic [2:0]          out_dir_r;
  logic                out_head_r;
  logic                out_tail_r;
  logic [DATA_W-1:0]   out_data_r;
  logic                err_r;
  logic [2:0]          held_dir_r;

  logic                accept_s;
  logic [2:0]          head_dir_s;
  logic                load_s;
  logic [2:0]          load_dir_s;
  logic                err_nxt_s;
  logic [2:0]          held_nxt_s;

  assign in_ready   = !out_valid_r || out_ready;
  assign accept_s   = in_valid && in_ready;
  assign head_dir_s = route_dir(node_addr, in_dest, dim_order);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: a head opens a packet unless it is also the tail; a tail closes it.
  always_comb begin
    state_nxt_s = state_r;
    if (!accept_s) begin
      state_nxt_s = state_r;
    end else if (in_head) begin
      state_nxt_s = in_tail ? ST_IDLE : ST_PKT;
    end else begin
      case (state_r)
        ST_PKT:  state_nxt_s = in_tail ? ST_IDLE : ST_PKT;
        ST_IDLE: state_nxt_s = ST_IDLE;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Output decode: what to load into the output register and whether to flag a framing error.
  always_comb begin
    load_s      = 1'b0;
    load_dir_s  = held_dir_r;
    err_nxt_s   = 1'b0;
    held_nxt_s  = held_dir_r;
    if (accept_s && in_head) begin
      load_s     = 1'b1;
      load_dir_s = head_dir_s;
      held_nxt_s = head_dir_s;
      err_nxt_s  = (state_r == ST_PKT);
    end else if (accept_s) begin
      case (state_r)
        ST_PKT: begin
          load_s     = 1'b1;
          load_dir_s = held_dir_r;
        end
        ST_IDLE: begin
          err_nxt_s = 1'b1;
        end
        default: begin
          err_nxt_s = 1'b1;
        end
      endcase
    end else begin
      load_s = 1'b0;
    end
  end

  // Output pipeline register, held route and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_dir_r   <= 3'b000;
      out_head_r  <= 1'b0;
      out_tail_r  <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
      err_r       <= 1'b0;
      held_dir_r  <= 3'b000;
    end else begin
      err_r      <= err_nxt_s;
      held_dir_r <= held_nxt_s;
      if (load_s) begin
        out_valid_r <= 1'b1;
        out_dir_r   <= load_dir_s;
        out_head_r  <= in_head;
        out_tail_r  <= in_tail;
        out_data_r  <= in_data;
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_dir   = out_dir_r;
  assign out_head  = out_head_r;
  assign out_tail  = out_tail_r;
  assign out_data  = out_data_r;
  assign err       = err_r;
  assign busy      = (state_r == ST_PKT);

endmodule
